lipsi_bcd_converter: RTL and testbench

Sequential double-dabble binary-to-BCD converter between the Lipsi accumulator output and the seven-segment display driver. It captures an unsigned binary value, either on an explicit start pulse or automatically when the value changes. It converts the value in one shift per clock and holds the packed BCD digits in a register, so the display scan logic no longer needs combinational divide and modulo.

---
 rtl/lipsi_bcd_converter_pkg.sv | 23 ++
 rtl/lipsi_bcd_converter_if.sv | 38 +++
 rtl/lipsi_bcd_converter_bcd_digit_adjust.sv | 21 ++
 rtl/lipsi_bcd_converter.sv | 124 ++++++++++++
 tb/tb_lipsi_bcd_converter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lipsi_bcd_converter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lipsi_pkg
//  Purpose  : Shared types and constants for the Lipsi BCD converter.
//             FSM state encoding and the double-dabble digit adjust constants.
//  Revision : 1.0 - initial release
// ============================================================================
package lipsi_pkg;

  // FSM states of the sequential converter
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A digit at or above the threshold would exceed 9 after doubling,
  // so it is pre-corrected by adding 3 before the shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage
`default_nettype wire

// File: rtl/lipsi_bcd_converter_if.sv
`default_nettype none
// ============================================================================
//  Module   : lipsi_bcd_converter_if
//  Purpose  : Bus bundle between the value source / display logic and the
//             BCD converter.
//  Ports    : value_i    - unsigned binary value (WIDTH bits)
//             start_i    - conversion request pulse
//             busy_o     - converter is shifting
//             done_o     - one-cycle pulse, results newly valid
//             bcd_o      - packed BCD digits, digit 0 in bits [3:0]
//             overflow_o - last conversion lost a nonzero top bit
//  Modports : master drives value/start, slave is the converter.
//  Revision : 1.0 - initial release
// ============================================================================
interface lipsi_bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();

  logic [WIDTH-1:0]    value_i;
  logic                start_i;
  logic                busy_o;
  logic                done_o;
  logic [4*DIGITS-1:0] bcd_o;
  logic                overflow_o;

  modport master (
    output value_i, start_i,
    input  busy_o, done_o, bcd_o, overflow_o
  );

  modport slave (
    input  value_i, start_i,
    output busy_o, done_o, bcd_o, overflow_o
  );

endinterface
`default_nettype wire

// File: rtl/lipsi_bcd_converter_bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_adjust
//  Purpose  : Combinational double-dabble digit correction: adds 3 to a BCD
//             digit that is 5 or more. The result is a plain 4-bit add with
//             no carry into the neighbouring digit.
//  Ports    : digit_i - 4-bit digit before correction
//             digit_o - 4-bit digit after correction
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
  import lipsi_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule
`default_nettype wire

// File: rtl/lipsi_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : lipsi_bcd_converter
//  Purpose  : Sequential double-dabble binary-to-BCD converter. Captures
//             value on start (or on a change of value when AUTO=1), shifts
//             one bit per clock and registers the packed BCD result.
//  Ports    : clk - system clock, rising edge
//             rst - asynchronous active-high reset
//             bus - lipsi_bcd_converter_if.slave (value/start in,
//                   busy/done/bcd/overflow out)
//  Revision : 1.0 - initial release
// ============================================================================
module lipsi_bcd_converter
  import lipsi_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit AUTO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  lipsi_bcd_converter_if.slave  bus
);

  localparam int             BW         = 4 * DIGITS;
  localparam int             CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

  state_t            state_q,   state_d;
  logic [WIDTH-1:0]  bin_q,     bin_d;
  logic [WIDTH-1:0]  last_q,    last_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [BW-1:0]     bcd_q,     bcd_d;
  logic              loss_q,    loss_d;
  logic              ovf_q,     ovf_d;
  logic [CW-1:0]     count_q,   count_d;

  logic [BW-1:0]     adj_w;
  logic [BW-1:0]     scratch_shift_w;
  logic              loss_step_w;
  logic              trigger_w;

  // Per-digit +3 correction of the scratch register
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj_w[4*g +: 4])
    );
  end

  // Adjusted scratch shifted left with the binary MSB entering bit 0;
  // the bit falling off the top digit feeds the loss flag.
  assign scratch_shift_w = {adj_w[BW-2:0], bin_q[WIDTH-1]};
  assign loss_step_w     = adj_w[BW-1];

  assign trigger_w = bus.start_i || (AUTO && (bus.value_i != last_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      last_q    <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      loss_q    <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      last_q    <= last_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      loss_q    <= loss_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    last_d    = last_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    loss_d    = loss_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    case (state_q)
      IDLE, DONE: begin
        // A trigger in DONE takes priority over the return to IDLE
        if (trigger_w) begin
          bin_d     = bus.value_i;
          last_d    = bus.value_i;
          scratch_d = '0;
          loss_d    = 1'b0;
          count_d   = '0;
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = scratch_shift_w;
        bin_d     = bin_q << 1;
        loss_d    = loss_q | loss_step_w;
        count_d   = count_q + 1'b1;
        if (count_q == LAST_COUNT) begin
          bcd_d   = scratch_shift_w;
          ovf_d   = loss_q | loss_step_w;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o     = (state_q == SHIFT);
  assign bus.done_o     = (state_q == DONE);
  assign bus.bcd_o      = bcd_q;
  assign bus.overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lipsi_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lipsi_bcd_converter
//  Purpose  : Directed self-checking bench for lipsi_bcd_converter.
//             dut_a: WIDTH=8 DIGITS=3 AUTO=1
//             dut_b: WIDTH=8 DIGITS=2 AUTO=1 (overflow cases)
//             dut_c: WIDTH=8 DIGITS=3 AUTO=0
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lipsi_bcd_converter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lipsi_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if_a ();
  lipsi_bcd_converter_if #(.WIDTH(8), .DIGITS(2)) if_b ();
  lipsi_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if_c ();

  lipsi_bcd_converter #(.WIDTH(8), .DIGITS(3), .AUTO(1'b1)) u_dut_a (
    .clk (clk), .rst (rst), .bus (if_a.slave)
  );
  lipsi_bcd_converter #(.WIDTH(8), .DIGITS(2), .AUTO(1'b1)) u_dut_b (
    .clk (clk), .rst (rst), .bus (if_b.slave)
  );
  lipsi_bcd_converter #(.WIDTH(8), .DIGITS(3), .AUTO(1'b0)) u_dut_c (
    .clk (clk), .rst (rst), .bus (if_c.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_a.value_i = '0; if_a.start_i = 1'b0;
    if_b.value_i = '0; if_b.start_i = 1'b0;
    if_c.value_i = '0; if_c.start_i = 1'b0;
    tick(); tick();
    n_checks++; if (if_a.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", if_a.busy_o); end
    n_checks++; if (if_a.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", if_a.done_o); end
    n_checks++; if (if_a.bcd_o !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h expected 000", if_a.bcd_o); end
    n_checks++; if (if_a.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", if_a.overflow_o); end
    n_checks++; if (if_b.bcd_o !== 8'h00) begin n_fail++; $display("FAIL reset_bcd_b: got %h expected 00", if_b.bcd_o); end
    rst = 1'b0;
    tick(); tick();
    // value equals the reset last_value, so nothing may start
    n_checks++; if (if_a.busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy got %b expected 0", if_a.busy_o); end
  endtask

  task automatic test_convert_max();
    int busy_cnt;
    int done_at;
    busy_cnt = 0; done_at = 0;
    if_a.value_i = 8'd255; if_a.start_i = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) if_a.start_i = 1'b0;
      if (if_a.busy_o === 1'b1) busy_cnt++;
      if (if_a.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (busy_cnt != 8) begin n_fail++; $display("FAIL max_busy_cycles: got %0d expected 8", busy_cnt); end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL max_done_latency: got %0d expected 9", done_at); end
    n_checks++; if (if_a.bcd_o !== 12'h255) begin n_fail++; $display("FAIL max_bcd: got %h expected 255", if_a.bcd_o); end
    n_checks++; if (if_a.overflow_o !== 1'b0) begin n_fail++; $display("FAIL max_ovf: got %b expected 0", if_a.overflow_o); end
    tick();
    n_checks++; if (if_a.done_o !== 1'b0 || if_a.busy_o !== 1'b0) begin n_fail++; $display("FAIL max_done_pulse: done %b busy %b expected 0 0", if_a.done_o, if_a.busy_o); end
  endtask

  task automatic test_zero_then_auto();
    int done_at;
    done_at = 0;
    if_a.value_i = 8'd0; if_a.start_i = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) if_a.start_i = 1'b0;
      if (if_a.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL zero_done_latency: got %0d expected 9", done_at); end
    n_checks++; if (if_a.bcd_o !== 12'h000) begin n_fail++; $display("FAIL zero_bcd: got %h expected 000", if_a.bcd_o); end
    // New value during DONE with no start: AUTO retriggers
    done_at = 0;
    if_a.value_i = 8'd10;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (if_a.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL auto_done_latency: got %0d expected 9", done_at); end
    n_checks++; if (if_a.bcd_o !== 12'h010) begin n_fail++; $display("FAIL auto_bcd: got %h expected 010", if_a.bcd_o); end
    tick();
  endtask

  task automatic test_start_while_busy();
    int done_at;
    int done_cnt;
    int busy_late;
    done_at = 0; done_cnt = 0; busy_late = 0;
    if_a.value_i = 8'd123; if_a.start_i = 1'b1;
    for (int j = 1; j <= 29; j++) begin
      tick();
      if (j == 1) if_a.start_i = 1'b0;
      if (j == 3) if_a.start_i = 1'b1;
      if (j == 4) if_a.start_i = 1'b0;
      if (if_a.done_o === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = j;
      end
      if (j > 10 && if_a.busy_o === 1'b1) busy_late++;
    end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 9", done_at); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (busy_late != 0) begin n_fail++; $display("FAIL busy_start_restart: busy cycles got %0d expected 0", busy_late); end
    n_checks++; if (if_a.bcd_o !== 12'h123) begin n_fail++; $display("FAIL busy_start_bcd: got %h expected 123", if_a.bcd_o); end
  endtask

  task automatic test_back_to_back();
    int done_at;
    int busy_cnt;
    done_at = 0;
    if_a.value_i = 8'd45; if_a.start_i = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) if_a.start_i = 1'b0;
      if (if_a.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9 || if_a.bcd_o !== 12'h045) begin n_fail++; $display("FAIL b2b_first: latency %0d bcd %h expected 9 045", done_at, if_a.bcd_o); end
    // Trigger while in DONE: next conversion starts at once
    done_at = 0; busy_cnt = 0;
    if_a.value_i = 8'd6; if_a.start_i = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) begin
        if_a.start_i = 1'b0;
        n_checks++; if (if_a.busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_trigger_in_done: busy got %b expected 1", if_a.busy_o); end
      end
      if (if_a.busy_o === 1'b1) busy_cnt++;
      if (if_a.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9 || busy_cnt != 8) begin n_fail++; $display("FAIL b2b_period: latency %0d busy %0d expected 9 8", done_at, busy_cnt); end
    n_checks++; if (if_a.bcd_o !== 12'h006) begin n_fail++; $display("FAIL b2b_bcd: got %h expected 006", if_a.bcd_o); end
    tick();
  endtask

  task automatic test_overflow();
    int done_at;
    done_at = 0;
    if_b.value_i = 8'd200; if_b.start_i = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) if_b.start_i = 1'b0;
      if (if_b.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 9", done_at); end
    n_checks++; if (if_b.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", if_b.overflow_o); end
    done_at = 0;
    if_b.value_i = 8'd99;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 4) begin
        // previous results hold while the next conversion runs
        n_checks++; if (if_b.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b expected 1", if_b.overflow_o); end
      end
      if (if_b.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL ovf99_latency: got %0d expected 9", done_at); end
    n_checks++; if (if_b.bcd_o !== 8'h99) begin n_fail++; $display("FAIL ovf99_bcd: got %h expected 99", if_b.bcd_o); end
    n_checks++; if (if_b.overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf99_clear: got %b expected 0", if_b.overflow_o); end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int done_at;
    done_at = 0;
    if_a.value_i = 8'd77; if_a.start_i = 1'b1;
    tick();
    if_a.start_i = 1'b0;
    tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (if_a.busy_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", if_a.busy_o); end
    n_checks++; if (if_a.done_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_done: got %b expected 0", if_a.done_o); end
    n_checks++; if (if_a.bcd_o !== 12'h000) begin n_fail++; $display("FAIL async_rst_bcd: got %h expected 000", if_a.bcd_o); end
    n_checks++; if (if_a.overflow_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_ovf: got %b expected 0", if_a.overflow_o); end
    #1;
    rst = 1'b0;
    // value 77 differs from the cleared last_value: first edge retriggers
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (if_a.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL rst_retrigger_latency: got %0d expected 9", done_at); end
    n_checks++; if (if_a.bcd_o !== 12'h077) begin n_fail++; $display("FAIL rst_retrigger_bcd: got %h expected 077", if_a.bcd_o); end
    tick();
  endtask

  task automatic test_auto_off();
    int done_at;
    int busy_cnt;
    int done_cnt;
    logic [7:0] vals [6];
    vals = '{8'd7, 8'd200, 8'd13, 8'd0, 8'd99, 8'd255};
    done_at = 0; busy_cnt = 0; done_cnt = 0;
    if_c.value_i = 8'd42; if_c.start_i = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) if_c.start_i = 1'b0;
      if (if_c.done_o === 1'b1 && done_at == 0) done_at = j;
    end
    n_checks++; if (done_at != 9 || if_c.bcd_o !== 12'h042) begin n_fail++; $display("FAIL noauto_start: latency %0d bcd %h expected 9 042", done_at, if_c.bcd_o); end
    tick();
    for (int j = 0; j < 30; j++) begin
      if (j % 5 == 0) if_c.value_i = vals[j / 5];
      tick();
      if (if_c.busy_o === 1'b1) busy_cnt++;
      if (if_c.done_o === 1'b1) done_cnt++;
    end
    n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL noauto_busy: got %0d expected 0", busy_cnt); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL noauto_done: got %0d expected 0", done_cnt); end
    n_checks++; if (if_c.bcd_o !== 12'h042) begin n_fail++; $display("FAIL noauto_bcd_hold: got %h expected 042", if_c.bcd_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_convert_max();
    test_zero_then_auto();
    test_start_while_busy();
    test_back_to_back();
    test_overflow();
    test_reset_mid_shift();
    test_auto_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
